wide_add_sequencer: RTL and testbench
=====================================

# wide_add_sequencer

Two-pass sequencer that performs 128-bit additions using the existing 64-bit combinational adder (ports A, B, CIN, SUM, COUT) as its arithmetic unit. It sits directly upstream of that adder and also consumes its results. It accepts 128-bit operand pairs over a valid/ready handshake and drives the low halves into the adder, then the high halves with the registered low carry. It returns the 128-bit result, carry-out and signed-overflow flag over a second valid/ready handshake.

## Interface
- HALF_W, default 64: adder width. Operand and result width is 2*HALF_W.
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  operand pair presented.
- IN_READY  out  1  sequencer can accept an operand pair.
- OP_A  in  2*HALF_W  operand A.
- OP_B  in  2*HALF_W  operand B.
- OP_CIN  in  1  carry-in to bit 0.
- ADD_A  out  HALF_W  to adder A.
- ADD_B  out  HALF_W  to adder B.
- ADD_CIN  out  1  to adder CIN.
- ADD_SUM  in  HALF_W  from adder SUM. Combinational function of ADD_A/ADD_B/ADD_CIN.
- ADD_COUT  in  1  from adder COUT.
- OUT_VALID  out  1  result available.
- OUT_READY  in  1  consumer takes result.
- RESULT  out  2*HALF_W  sum.
- CARRY  out  1  carry out of bit 2*HALF_W-1.
- OVERFLOW  out  1  two's-complement overflow.

## Operation
- Operand capture: on an accept edge (IN_VALID & IN_READY), OP_A, OP_B and OP_CIN are registered. Inputs are ignored at all other edges.
- States:
  - IDLE: IN_READY=1. On accept, go to LO.
  - LO: ADD_A=A[HALF_W-1:0], ADD_B=B[HALF_W-1:0], ADD_CIN=captured CIN. At the edge, RESULT[HALF_W-1:0] is loaded from ADD_SUM and the carry latch is loaded from ADD_COUT. Go to HI.
  - HI: ADD_A=A[2W-1:W], ADD_B=B[2W-1:W], ADD_CIN=carry latch. At the edge, RESULT[2W-1:W] is loaded from ADD_SUM and CARRY from ADD_COUT. OVERFLOW is loaded as (A[msb]==B[msb]) & (ADD_SUM[msb]!=A[msb]). Go to DONE.
  - DONE: OUT_VALID=1. When OUT_READY=1 at the edge, go to IDLE. Otherwise stay in DONE.
- Adder drive outside LO/HI: ADD_A, ADD_B and ADD_CIN are driven 0 in IDLE and DONE.
- IN_READY: equals (state==IDLE). It is never high while a result is held, so there is no accept in the same cycle as an output handshake.
- Result stability: RESULT, CARRY and OVERFLOW hold their values from the HI edge until the next HI edge. They must stay stable throughout DONE.
- Arithmetic rule: all arithmetic is modulo 2^(2*HALF_W). CARRY is the true unsigned carry. OVERFLOW uses signed interpretation of the full 128-bit operands.
- Reset: RST asynchronously forces IDLE. It also clears every register, including the operand registers, carry latch, RESULT, CARRY, OVERFLOW and OUT_VALID.
  - A reset during LO, HI or DONE aborts the operation and discards the result.
  - IN_READY is forced 0 while RST is high, and rises in the first cycle after release.

## Timing
- Accept-to-result latency: accept at edge E0. State is LO in cycle E0..E1 and HI in cycle E1..E2. OUT_VALID rises immediately after E2.
- Output handshake: completes at the first edge E≥E3 where OUT_READY=1. IN_READY rises after that edge.
- Throughput: minimum 4 cycles per operation when OUT_READY is held 1.
- Adder timing: the adder is combinational with no registers. ADD_* are Moore outputs, decoded from the state and operand registers only, and must not depend combinationally on IN_* or OUT_READY.
- Output reset values: IN_READY=0 while RST is high (then 1). ADD_A=0, ADD_B=0, ADD_CIN=0, OUT_VALID=0, RESULT=0, CARRY=0, OVERFLOW=0.

## Test plan
- Low-to-high carry: A=128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, B=1, CIN=0. Expect RESULT=128'h0000_0000_0000_0001_0000_0000_0000_0000, CARRY=0, OVERFLOW=0. ADD_CIN=1 during HI.
- Signed overflow: A=128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, B=1. Expect RESULT=128'h8000_0000_0000_0000_0000_0000_0000_0000, CARRY=0, OVERFLOW=1.
- Full wrap: A=all ones, B=0, CIN=1. Expect RESULT=0, CARRY=1, OVERFLOW=0.
- Back-pressure: run any operation with OUT_READY held 0 for 5 cycles after OUT_VALID rises. Expect RESULT, CARRY and OVERFLOW stable, OUT_VALID=1 and IN_READY=0 throughout. Raise OUT_READY: OUT_VALID falls and IN_READY rises the next cycle. A second operand pair offered during DONE is not accepted.
- Latency/throughput: issue 3 back-to-back operations with IN_VALID and OUT_READY held 1. Expect accepts exactly 4 cycles apart and OUT_VALID exactly 2 cycles after each accept edge.
- Reset mid-operation: assert RST asynchronously during HI. Expect immediate IDLE, all outputs 0 and no OUT_VALID pulse. After release, a new operation (5+7) produces RESULT=12.

Source files
------------

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer
// Performs a 2*HALF_W-bit addition in two passes through an external
// HALF_W-bit combinational adder: low halves first, then high halves with the
// registered low-half carry. Operands arrive on a valid/ready handshake and
// the result (sum, unsigned carry, signed overflow) leaves on a second one.
//
// Ports
//   CLK, RST            rising-edge clock, asynchronous active-high reset
//   IN_VALID/IN_READY   operand handshake
//   OP_A, OP_B, OP_CIN  2*HALF_W-bit operands and carry-in
//   ADD_A/B/CIN         drive to the external adder (Moore, from registers only)
//   ADD_SUM/ADD_COUT    external adder outputs
//   OUT_VALID/OUT_READY result handshake
//   RESULT, CARRY, OVERFLOW  registered result, held from one HI pass to the next
module wide_add_sequencer #(
  parameter int HALF_W = 64
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [2*HALF_W-1:0] OP_A,
  input  logic [2*HALF_W-1:0] OP_B,
  input  logic                OP_CIN,
  output logic [HALF_W-1:0]   ADD_A,
  output logic [HALF_W-1:0]   ADD_B,
  output logic                ADD_CIN,
  input  logic [HALF_W-1:0]   ADD_SUM,
  input  logic                ADD_COUT,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [2*HALF_W-1:0] RESULT,
  output logic                CARRY,
  output logic                OVERFLOW
);

  localparam int W2 = 2 * HALF_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [W2-1:0]   a_q, a_d;
  logic [W2-1:0]   b_q, b_d;
  logic            cin_q, cin_d;
  logic            carry_lo_q, carry_lo_d;
  logic [W2-1:0]   result_q, result_d;
  logic            carry_q, carry_d;
  logic            ovf_q, ovf_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  // State and datapath registers; reset clears everything, aborting any operation.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      carry_lo_q  <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      carry_lo_q  <= carry_lo_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and datapath update; handshake flags are registered from the next state.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    carry_lo_d = carry_lo_q;
    result_d   = result_q;
    carry_d    = carry_q;
    ovf_d      = ovf_q;
    case (state_q)
      S_IDLE: begin
        // in_ready_q is low for one cycle after reset release, so it gates the accept.
        if (IN_VALID && in_ready_q) begin
          a_d     = OP_A;
          b_d     = OP_B;
          cin_d   = OP_CIN;
          state_d = S_LO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LO: begin
        result_d[HALF_W-1:0] = ADD_SUM;
        carry_lo_d           = ADD_COUT;
        state_d              = S_HI;
      end
      S_HI: begin
        result_d[W2-1:HALF_W] = ADD_SUM;
        carry_d               = ADD_COUT;
        // Signed overflow: like-signed operands whose sum changes sign.
        ovf_d   = (a_q[W2-1] == b_q[W2-1]) && (ADD_SUM[HALF_W-1] != a_q[W2-1]);
        state_d = S_DONE;
      end
      S_DONE: begin
        if (OUT_READY) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // Adder drive decoded from registered state and operands only (kept apart from
  // the next-state logic, which reads the adder outputs).
  always_comb begin
    ADD_A   = '0;
    ADD_B   = '0;
    ADD_CIN = 1'b0;
    case (state_q)
      S_LO: begin
        ADD_A   = a_q[HALF_W-1:0];
        ADD_B   = b_q[HALF_W-1:0];
        ADD_CIN = cin_q;
      end
      S_HI: begin
        ADD_A   = a_q[W2-1:HALF_W];
        ADD_B   = b_q[W2-1:HALF_W];
        ADD_CIN = carry_lo_q;
      end
      default: begin
        ADD_A   = '0;
        ADD_B   = '0;
        ADD_CIN = 1'b0;
      end
    endcase
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign RESULT    = result_q;
  assign CARRY     = carry_q;
  assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed testbench for wide_add_sequencer with a behavioural 64-bit adder.
module tb_wide_add_sequencer;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] op_a;
  logic [127:0] op_b;
  logic         op_cin;
  logic [63:0]  add_a;
  logic [63:0]  add_b;
  logic         add_cin;
  logic [63:0]  add_sum;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] result;
  logic         carry;
  logic         overflow;

  int n_cmp;
  int n_fail;

  wide_add_sequencer #(.HALF_W(64)) dut (
    .CLK(clk), .RST(rst),
    .IN_VALID(in_valid), .IN_READY(in_ready),
    .OP_A(op_a), .OP_B(op_b), .OP_CIN(op_cin),
    .ADD_A(add_a), .ADD_B(add_b), .ADD_CIN(add_cin),
    .ADD_SUM(add_sum), .ADD_COUT(add_cout),
    .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .RESULT(result), .CARRY(carry), .OVERFLOW(overflow)
  );

  // External combinational adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {64'd0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one operation; returns at the sample just after the HI edge.
  task automatic run_op(input logic [127:0] a, input logic [127:0] b, input logic cin,
                        output logic [63:0] lo_a, output logic hi_cin, output logic ok);
    ok = 1'b0;
    lo_a = 64'd0;
    hi_cin = 1'b0;
    for (int i = 0; i < 20 && !in_ready; i++) tick;
    if (!in_ready) return;
    op_a = a; op_b = b; op_cin = cin; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    lo_a = add_a;
    tick;
    hi_cin = add_cin;
    tick;
    ok = out_valid;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_a = 128'd0; op_b = 128'd0; op_cin = 1'b0;
    #12;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_cmp++;
    if ({out_valid, carry, overflow, add_cin} !== 4'b0000 || result !== 128'd0 ||
        add_a !== 64'd0 || add_b !== 64'd0) begin
      n_fail++; $display("FAIL reset_outputs: got v=%b c=%b o=%b res=%h a=%h expected all 0",
                         out_valid, carry, overflow, result, add_a);
    end
    tick;
    rst = 1'b0;
    tick;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_low_high_carry;
    logic [63:0] lo_a; logic hi_cin; logic ok;
    out_ready = 1'b1;
    run_op(128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, lo_a, hi_cin, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL carry_valid: got %b expected 1", ok); end
    n_cmp++;
    if (lo_a !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL carry_lo_add_a: got %h expected ffffffffffffffff", lo_a); end
    n_cmp++;
    if (hi_cin !== 1'b1) begin n_fail++; $display("FAIL carry_hi_cin: got %b expected 1", hi_cin); end
    n_cmp++;
    if (result !== 128'h0000_0000_0000_0001_0000_0000_0000_0000 || carry !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL carry_result: got %h c=%b o=%b expected 00000000000000010000000000000000 c=0 o=0", result, carry, overflow);
    end
    tick;
  endtask

  task automatic test_overflow;
    logic [63:0] lo_a; logic hi_cin; logic ok;
    out_ready = 1'b1;
    run_op(128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, lo_a, hi_cin, ok);
    n_cmp++;
    if (ok !== 1'b1 || result !== 128'h8000_0000_0000_0000_0000_0000_0000_0000 || carry !== 1'b0 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL overflow: got v=%b %h c=%b o=%b expected v=1 80000000000000000000000000000000 c=0 o=1", ok, result, carry, overflow);
    end
    tick;
  endtask

  task automatic test_full_wrap;
    logic [63:0] lo_a; logic hi_cin; logic ok;
    out_ready = 1'b1;
    run_op({128{1'b1}}, 128'd0, 1'b1, lo_a, hi_cin, ok);
    n_cmp++;
    if (ok !== 1'b1 || result !== 128'd0 || carry !== 1'b1 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL full_wrap: got v=%b %h c=%b o=%b expected v=1 0 c=1 o=0", ok, result, carry, overflow);
    end
    tick;
  endtask

  task automatic test_back_pressure;
    logic [63:0] lo_a; logic hi_cin; logic ok;
    out_ready = 1'b0;
    run_op(128'd3, 128'd5, 1'b0, lo_a, hi_cin, ok);
    n_cmp++;
    if (ok !== 1'b1 || result !== 128'd8) begin n_fail++; $display("FAIL bp_first: got v=%b %h expected v=1 8", ok, result); end
    // Offer a second pair while the result is held
    op_a = 128'd99; op_b = 128'd1; op_cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 128'd8 || carry !== 1'b0 || overflow !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b r=%b %h c=%b o=%b expected v=1 r=0 8 c=0 o=0",
                           i, out_valid, in_ready, result, carry, overflow);
      end
    end
    out_ready = 1'b1; in_valid = 1'b0;
    tick;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
    end
    n_cmp++;
    if (add_a !== 64'd0 || result !== 128'd8) begin
      n_fail++; $display("FAIL bp_no_accept: got add_a=%h res=%h expected 0 and 8", add_a, result);
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] av [3];
    logic [127:0] bv [3];
    logic         cv [3];
    logic [127:0] ev [3];
    int acc_cyc [3];
    int val_cyc [3];
    int na; int nv; logic prev_valid; logic acc;
    av[0] = 128'd10; bv[0] = 128'd20; cv[0] = 1'b0; ev[0] = 128'd30;
    av[1] = 128'h1_0000_0000_0000_0000; bv[1] = 128'd5; cv[1] = 1'b1; ev[1] = 128'h1_0000_0000_0000_0006;
    av[2] = 128'd3; bv[2] = 128'd4; cv[2] = 1'b0; ev[2] = 128'd7;
    na = 0; nv = 0; prev_valid = out_valid;
    out_ready = 1'b1;
    op_a = av[0]; op_b = bv[0]; op_cin = cv[0]; in_valid = 1'b1;
    for (int cyc = 1; cyc <= 40 && nv < 3; cyc++) begin
      acc = in_valid && in_ready;
      tick;
      if (acc) begin
        acc_cyc[na] = cyc;
        na++;
        if (na < 3) begin op_a = av[na]; op_b = bv[na]; op_cin = cv[na]; end
        else in_valid = 1'b0;
      end
      if (out_valid && !prev_valid && nv < 3) begin
        val_cyc[nv] = cyc;
        n_cmp++;
        if (result !== ev[nv]) begin n_fail++; $display("FAIL b2b_result[%0d]: got %h expected %h", nv, result, ev[nv]); end
        nv++;
      end
      prev_valid = out_valid;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (na != 3 || nv != 3) begin
      n_fail++; $display("FAIL b2b_count: got accepts=%0d results=%0d expected 3 and 3", na, nv);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (val_cyc[i] - acc_cyc[i] != 2) begin
          n_fail++; $display("FAIL b2b_latency[%0d]: got %0d expected 2", i, val_cyc[i] - acc_cyc[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        n_cmp++;
        if (acc_cyc[i] - acc_cyc[i-1] != 4) begin
          n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d expected 4", i, acc_cyc[i] - acc_cyc[i-1]);
        end
      end
    end
    tick;
  endtask

  task automatic test_reset_mid_op;
    logic [63:0] lo_a; logic hi_cin; logic ok; logic seen_valid;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) tick;
    op_a = {128{1'b1}}; op_b = 128'd0; op_cin = 1'b1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    n_cmp++;
    if (add_a !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL rst_mid_in_hi: got add_a=%h expected ffffffffffffffff", add_a); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (add_a !== 64'd0 || add_b !== 64'd0 || add_cin !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_adder: got a=%h b=%h cin=%b r=%b expected all 0", add_a, add_b, add_cin, in_ready);
    end
    n_cmp++;
    if (out_valid !== 1'b0 || result !== 128'd0 || carry !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_result: got v=%b %h c=%b o=%b expected all 0", out_valid, result, carry, overflow);
    end
    tick;
    tick;
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (out_valid) seen_valid = 1'b1;
    end
    n_cmp++;
    if (seen_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_valid: got %b expected 0", seen_valid); end
    run_op(128'd5, 128'd7, 1'b0, lo_a, hi_cin, ok);
    n_cmp++;
    if (ok !== 1'b1 || result !== 128'd12 || carry !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_after: got v=%b %h c=%b o=%b expected v=1 12 c=0 o=0", ok, result, carry, overflow);
    end
    tick;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset;
    test_low_high_carry;
    test_overflow;
    test_full_wrap;
    test_back_pressure;
    test_back_to_back;
    test_reset_mid_op;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
